// File: rtl/multimode_counter.sv
// Parametrised loadable up/down counter with enable prescaler, programmable limit
// and four end-of-count behaviours (wrap, saturate, one-shot, bounce).
module multimode_counter #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  enable,
    input  logic                  up_dn,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  oe,
    output logic [WIDTH-1:0]      q,
    output logic                  tc,
    output logic                  done
);

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_BOUNCE  = 2'b11;

    localparam logic [WIDTH-1:0]      CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]      CNT_ONE  = WIDTH'(1'b1);
    localparam logic [PRESCALE_W-1:0] PRE_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] PRE_ONE  = PRESCALE_W'(1'b1);

    logic [WIDTH-1:0]      cnt_r;
    logic [PRESCALE_W-1:0] pre_cnt_r;
    logic                  dir_r;
    logic                  tc_r;
    logic                  done_r;

    logic [WIDTH-1:0]      load_clamp_s;
    logic                  tick_s;
    logic                  eff_up_s;
    logic                  at_term_s;
    logic [WIDTH-1:0]      limit_dec_s;

    logic [WIDTH-1:0]      step_cnt_s;
    logic                  step_dir_s;
    logic                  step_done_s;

    logic [WIDTH-1:0]      cnt_nxt_s;
    logic [PRESCALE_W-1:0] pre_nxt_s;
    logic                  dir_nxt_s;
    logic                  tc_nxt_s;
    logic                  done_nxt_s;

    // Decode tick, effective direction and terminal condition from current state.
    always_comb begin
        load_clamp_s = (load_value > limit) ? limit : load_value;
        tick_s       = enable & ~load & ~done_r & (pre_cnt_r == prescale);
        eff_up_s     = (mode == MODE_BOUNCE) ? dir_r : up_dn;
        // Using >= lets a lowered limit pull an out-of-range count back in.
        at_term_s    = eff_up_s ? (cnt_r >= limit) : (cnt_r == CNT_ZERO);
        limit_dec_s  = (limit == CNT_ZERO) ? CNT_ZERO : (limit - CNT_ONE);
    end

    // Result of one counting step, including the per-mode terminal action.
    always_comb begin
        step_cnt_s  = cnt_r;
        step_dir_s  = dir_r;
        step_done_s = 1'b0;
        if (!at_term_s) begin
            if (eff_up_s) begin
                step_cnt_s = cnt_r + CNT_ONE;
            end else begin
                step_cnt_s = cnt_r - CNT_ONE;
            end
        end else begin
            case (mode)
                MODE_WRAP: begin
                    step_cnt_s = eff_up_s ? CNT_ZERO : limit;
                end
                MODE_SAT: begin
                    step_cnt_s = eff_up_s ? limit : CNT_ZERO;
                end
                MODE_ONESHOT: begin
                    step_cnt_s  = cnt_r;
                    step_done_s = 1'b1;
                end
                MODE_BOUNCE: begin
                    // A zero limit pins the count at 0 while the direction keeps flipping.
                    if (eff_up_s) begin
                        step_cnt_s = limit_dec_s;
                        step_dir_s = 1'b0;
                    end else begin
                        step_cnt_s = (limit == CNT_ZERO) ? CNT_ZERO : CNT_ONE;
                        step_dir_s = 1'b1;
                    end
                end
                default: begin
                    step_cnt_s = cnt_r;
                end
            endcase
        end
    end

    // Next-state selection: load first, otherwise prescaler and counting step.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        pre_nxt_s  = pre_cnt_r;
        dir_nxt_s  = dir_r;
        tc_nxt_s   = 1'b0;
        done_nxt_s = done_r;
        if (load) begin
            cnt_nxt_s  = load_clamp_s;
            pre_nxt_s  = PRE_ZERO;
            dir_nxt_s  = up_dn;
            tc_nxt_s   = 1'b0;
            done_nxt_s = 1'b0;
        end else begin
            // Once done is set the prescaler freezes so no further ticks occur.
            if (tick_s) begin
                pre_nxt_s = PRE_ZERO;
            end else if (enable && !done_r) begin
                pre_nxt_s = pre_cnt_r + PRE_ONE;
            end else begin
                pre_nxt_s = pre_cnt_r;
            end

            if (tick_s) begin
                cnt_nxt_s  = step_cnt_s;
                tc_nxt_s   = at_term_s;
                done_nxt_s = done_r | step_done_s;
            end else begin
                cnt_nxt_s  = cnt_r;
                tc_nxt_s   = 1'b0;
                done_nxt_s = done_r;
            end

            if (mode != MODE_BOUNCE) begin
                dir_nxt_s = up_dn;
            end else if (tick_s) begin
                dir_nxt_s = step_dir_s;
            end else begin
                dir_nxt_s = dir_r;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r     <= CNT_ZERO;
            pre_cnt_r <= PRE_ZERO;
            dir_r     <= 1'b1;
            tc_r      <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            pre_cnt_r <= pre_nxt_s;
            dir_r     <= dir_nxt_s;
            tc_r      <= tc_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

    assign q    = cnt_r & {WIDTH{oe}};
    assign tc   = tc_r;
    assign done = done_r;

endmodule

// File: tb/tb_multimode_counter.sv
// Scoreboard bench for multimode_counter: each scenario pushes expected outputs per
// driven cycle and pops/compares them one clock later.
module tb_multimode_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [7:0] load_value;
    logic       enable;
    logic       up_dn;
    logic [1:0] mode;
    logic [7:0] limit;
    logic [3:0] prescale;
    logic       oe;
    logic [7:0] q;
    logic       tc;
    logic       done;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] q;
        logic       tc;
        logic       done;
    } exp_t;

    typedef struct packed {
        logic       en;
        logic       ld;
        logic [7:0] lv;
        logic       ud;
        logic [7:0] lim;
        logic       oe;
        logic [7:0] eq;
        logic       etc;
        logic       edone;
    } row_t;

    exp_t sb[$];

    multimode_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .load_value(load_value),
        .enable(enable), .up_dn(up_dn), .mode(mode), .limit(limit),
        .prescale(prescale), .oe(oe), .q(q), .tc(tc), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d", total);
        $fatal(1);
    end

    function automatic row_t r(input int en, input int ld, input int lv, input int ud,
                               input int lim, input int o, input int eq, input int et,
                               input int ed);
        row_t x;
        x.en = en[0]; x.ld = ld[0]; x.lv = lv[7:0]; x.ud = ud[0];
        x.lim = lim[7:0]; x.oe = o[0]; x.eq = eq[7:0]; x.etc = et[0]; x.edone = ed[0];
        return x;
    endfunction

    task automatic apply(input row_t x);
        exp_t e;
        enable = x.en; load = x.ld; load_value = x.lv; up_dn = x.ud;
        limit = x.lim; oe = x.oe;
        e.q = x.eq; e.tc = x.etc; e.done = x.edone;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t e;
        rst_n = 1'b0; load = 1'b1; enable = 1'b1; load_value = 8'd77; up_dn = 1'b1;
        mode = 2'b00; limit = 8'd5; prescale = 4'd0; oe = 1'b1;
        e.q = 8'd0; e.tc = 1'b0; e.done = 1'b0;
        sb.push_back(e);
        repeat (2) @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if (q !== e.q || tc !== e.tc || done !== e.done) begin
            bad++;
            $display("FAIL reset_hold: got q=%0d tc=%b done=%b, want q=%0d tc=%b done=%b",
                     q, tc, done, e.q, e.tc, e.done);
        end
        rst_n = 1'b1;
        rows.push_back(r(1,0,0,1,5,1, 1,0,0)); rows.push_back(r(1,0,0,1,5,1, 2,0,0));
        rows.push_back(r(1,0,0,1,5,1, 3,0,0)); rows.push_back(r(1,0,0,1,5,1, 4,0,0));
        rows.push_back(r(1,0,0,1,5,1, 5,0,0)); rows.push_back(r(1,0,0,1,5,1, 0,1,0));
        rows.push_back(r(1,0,0,1,5,1, 1,0,0));
        for (int i = 0; i < rows.size(); i++) begin
            apply(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (q !== e.q || tc !== e.tc || done !== e.done) begin
                bad++;
                $display("FAIL wrap_up[%0d]: got q=%0d tc=%b done=%b, want q=%0d tc=%b done=%b",
                         i, q, tc, done, e.q, e.tc, e.done);
            end
        end
    endtask

    task automatic test_prescale();
        row_t rows[$];
        exp_t e;
        mode = 2'b00; prescale = 4'd2;
        rows.push_back(r(1,1,0,1,255,1, 0,0,0));
        rows.push_back(r(1,0,0,1,255,1, 0,0,0)); rows.push_back(r(1,0,0,1,255,1, 0,0,0));
        rows.push_back(r(1,0,0,1,255,1, 1,0,0)); rows.push_back(r(1,0,0,1,255,1, 1,0,0));
        rows.push_back(r(1,0,0,1,255,1, 1,0,0)); rows.push_back(r(1,0,0,1,255,1, 2,0,0));
        rows.push_back(r(1,0,0,1,255,1, 2,0,0));
        for (int k = 0; k < 4; k++) rows.push_back(r(0,0,0,1,255,1, 2,0,0));
        rows.push_back(r(1,0,0,1,255,1, 2,0,0)); rows.push_back(r(1,0,0,1,255,1, 3,0,0));
        rows.push_back(r(1,0,0,1,255,1, 3,0,0));
        rows.push_back(r(1,1,10,1,255,1, 10,0,0));
        rows.push_back(r(1,0,0,1,255,1, 10,0,0)); rows.push_back(r(1,0,0,1,255,1, 10,0,0));
        rows.push_back(r(1,0,0,1,255,1, 11,0,0));
        for (int i = 0; i < rows.size(); i++) begin
            apply(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (q !== e.q || tc !== e.tc || done !== e.done) begin
                bad++;
                $display("FAIL prescale[%0d]: got q=%0d tc=%b done=%b, want q=%0d tc=%b done=%b",
                         i, q, tc, done, e.q, e.tc, e.done);
            end
        end
    endtask

    task automatic test_sat_down();
        row_t rows[$];
        exp_t e;
        mode = 2'b01; prescale = 4'd0;
        rows.push_back(r(0,1,2,0,10,1, 2,0,0));
        rows.push_back(r(1,0,0,0,10,1, 1,0,0)); rows.push_back(r(1,0,0,0,10,1, 0,0,0));
        rows.push_back(r(1,0,0,0,10,1, 0,1,0)); rows.push_back(r(1,0,0,0,10,1, 0,1,0));
        rows.push_back(r(1,0,0,0,10,1, 0,1,0));
        rows.push_back(r(1,1,9,0,6,1, 6,0,0));
        rows.push_back(r(1,0,0,1,6,1, 6,1,0));
        for (int i = 0; i < rows.size(); i++) begin
            apply(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (q !== e.q || tc !== e.tc || done !== e.done) begin
                bad++;
                $display("FAIL sat[%0d]: got q=%0d tc=%b done=%b, want q=%0d tc=%b done=%b",
                         i, q, tc, done, e.q, e.tc, e.done);
            end
        end
    endtask

    task automatic test_oneshot();
        row_t rows[$];
        exp_t e;
        mode = 2'b10; prescale = 4'd0;
        rows.push_back(r(0,1,0,1,3,1, 0,0,0));
        rows.push_back(r(1,0,0,1,3,1, 1,0,0)); rows.push_back(r(1,0,0,1,3,1, 2,0,0));
        rows.push_back(r(1,0,0,1,3,1, 3,0,0)); rows.push_back(r(1,0,0,1,3,1, 3,1,1));
        for (int k = 0; k < 10; k++) rows.push_back(r(1,0,0,1,3,1, 3,0,1));
        rows.push_back(r(1,1,0,1,3,1, 0,0,0));
        rows.push_back(r(1,0,0,1,3,1, 1,0,0));
        for (int i = 0; i < rows.size(); i++) begin
            apply(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (q !== e.q || tc !== e.tc || done !== e.done) begin
                bad++;
                $display("FAIL oneshot[%0d]: got q=%0d tc=%b done=%b, want q=%0d tc=%b done=%b",
                         i, q, tc, done, e.q, e.tc, e.done);
            end
        end
    endtask

    task automatic test_bounce();
        row_t rows[$];
        exp_t e;
        mode = 2'b11; prescale = 4'd0;
        rows.push_back(r(0,1,0,1,3,1, 0,0,0));
        rows.push_back(r(1,0,0,0,3,1, 1,0,0)); rows.push_back(r(1,0,0,0,3,1, 2,0,0));
        rows.push_back(r(1,0,0,0,3,1, 3,0,0)); rows.push_back(r(1,0,0,0,3,1, 2,1,0));
        rows.push_back(r(1,0,0,0,3,1, 1,0,0)); rows.push_back(r(1,0,0,0,3,1, 0,0,0));
        rows.push_back(r(1,0,0,0,3,1, 1,1,0)); rows.push_back(r(1,0,0,0,3,1, 2,0,0));
        rows.push_back(r(0,1,0,1,0,1, 0,0,0));
        for (int k = 0; k < 4; k++) rows.push_back(r(1,0,0,1,0,1, 0,1,0));
        for (int i = 0; i < rows.size(); i++) begin
            apply(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (q !== e.q || tc !== e.tc || done !== e.done) begin
                bad++;
                $display("FAIL bounce[%0d]: got q=%0d tc=%b done=%b, want q=%0d tc=%b done=%b",
                         i, q, tc, done, e.q, e.tc, e.done);
            end
        end
    endtask

    task automatic test_edges();
        row_t rows[$];
        exp_t e;
        mode = 2'b00; prescale = 4'd0;
        rows.push_back(r(0,1,50,1,200,1, 50,0,0));
        rows.push_back(r(1,0,0,1,10,1, 0,1,0));
        rows.push_back(r(1,0,0,1,10,1, 1,0,0));
        rows.push_back(r(1,0,0,1,10,0, 0,0,0)); rows.push_back(r(1,0,0,1,10,0, 0,0,0));
        rows.push_back(r(1,0,0,1,10,0, 0,0,0));
        rows.push_back(r(0,0,0,1,10,1, 4,0,0));
        rows.push_back(r(0,1,0,0,10,1, 0,0,0));
        rows.push_back(r(1,0,0,0,10,1, 10,1,0));
        rows.push_back(r(1,0,0,0,10,1, 9,0,0));
        for (int i = 0; i < rows.size(); i++) begin
            apply(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (q !== e.q || tc !== e.tc || done !== e.done) begin
                bad++;
                $display("FAIL edges[%0d]: got q=%0d tc=%b done=%b, want q=%0d tc=%b done=%b",
                         i, q, tc, done, e.q, e.tc, e.done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_prescale();
        test_sat_down();
        test_oneshot();
        test_bounce();
        test_edges();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multimode_counter.md
# multimode_counter

Parametrised successor to the team's fixed 8-bit loadable counter. It adds configurable width, a programmable terminal value (`limit`), up/down counting and an enable prescaler. It has four end-of-count modes (wrap, saturate, one-shot, bounce), a terminal-count pulse and a one-shot done flag. It sits between the Tiny Tapeout top-level pins and the output bus, in the same position as the existing counter, and is fully synchronous to the single system clock.

## Interface
- `WIDTH`, default 8: counter width in bits; ≥ 2.
- `PRESCALE_W`, default 4: width of the prescale divider field; ≥ 1.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset is synchronous and active-low.
- `load`  in  1  load `load_value` this cycle; highest priority after reset.
- `load_value`  in  `WIDTH`  value to load; clamped to `limit`.
- `enable`  in  1  count-enable qualifier, fed to the prescaler.
- `up_dn`  in  1  direction: 1 = up, 0 = down. Also seeds the bounce direction on load.
- `mode`  in  2  end-of-count behaviour: 00 WRAP, 01 SAT, 10 ONESHOT, 11 BOUNCE.
- `limit`  in  `WIDTH`  terminal value; the count range is 0..`limit`.
- `prescale`  in  `PRESCALE_W`  step on every (`prescale`+1)-th enabled cycle.
- `oe`  in  1  output enable; `q` = 0 when low.
- `q`  out  `WIDTH`  count value, gated by `oe` (combinational AND).
- `tc`  out  1  registered one-cycle terminal-count pulse.
- `done`  out  1  ONESHOT has completed; held until load or reset.

## Operation
State registers:
- `cnt` (`WIDTH`)
- `pre_cnt` (`PRESCALE_W`)
- `dir` (1 = up)
- `tc_r`
- `done_r`

Reset (`rst_n`=0 at a clock edge): `cnt`=0, `pre_cnt`=0, `dir`=1, `tc`=0, `done`=0. Reset overrides every other input.

Load (`load`=1):
- `cnt` ← min(`load_value`, `limit`).
- `pre_cnt` ← 0, `dir` ← `up_dn`, `done` ← 0, `tc` ← 0.
- `enable` is ignored that cycle.

Prescaler tick:
- A tick occurs when `enable`=1, `load`=0, `done`=0 and `pre_cnt`==`prescale`. On a tick, `pre_cnt` ← 0.
- When `enable`=1 and there is no tick, `pre_cnt` increments.
- When `enable`=0, `pre_cnt` holds.
- `prescale`=0 gives a tick on every enabled cycle.

Effective direction: `dir` in BOUNCE mode, otherwise `up_dn`. When `mode`≠BOUNCE, `dir` ← `up_dn` every cycle.

Terminal condition, evaluated on the current `cnt`:
- up: `cnt` ≥ `limit` (using ≥ covers `limit` being lowered below `cnt`).
- down: `cnt` == 0.

On a tick:
- Not at terminal: `cnt` ± 1 in the effective direction.
- At terminal, `tc` ← 1 for one cycle, then per mode:
  - WRAP: up → 0; down → `limit`.
  - SAT: `cnt` holds. `tc` pulses on every further terminal tick.
  - ONESHOT: `cnt` holds; `done` ← 1. Further ticks are suppressed: `pre_cnt` frozen, no `tc`.
  - BOUNCE: up → `limit`−1 with `dir` ← 0; down → 1 with `dir` ← 1. If `limit`==0, `cnt` stays 0, `dir` still toggles and `tc` pulses every tick.
- In WRAP/SAT/BOUNCE, if `cnt` > `limit` when counting up, the terminal action is applied. The WRAP result is 0; the SAT and BOUNCE results use `limit` (SAT sets `cnt` ← `limit`).

Without a tick, `tc` ← 0.

A mode change mid-count takes effect on the next tick. `done` is only cleared by load or reset, even if `mode` leaves ONESHOT.

## Timing
- All outputs except `q` are registered. `q` = `cnt` & {`WIDTH`{`oe`}}, combinational from `oe`.
- Load-to-`q` latency: 1 cycle. Tick-to-`q` latency: 1 cycle. `tc` rises in the same cycle the terminal-step result appears on `q`.
- With `enable` held high and `prescale`=P, consecutive steps are exactly P+1 cycles apart. A load restarts the prescale phase.
- Deasserting `rst_n` mid-count returns all state to reset values on the next edge. A load and a tick in the same cycle resolve in favour of load.

## Test plan
- Reset: WIDTH=8; hold `rst_n`=0 with `load`=1 and `enable`=1 → `q`=0, `tc`=0, `done`=0. Release with `enable`=1, `prescale`=0, `mode`=WRAP, `limit`=5, up → `q` sequence 1,2,3,4,5,0,1; `tc`=1 only in the cycle `q` shows 0.
- Prescale: `prescale`=2, `limit`=255 → `q` steps every 3rd cycle. Drop `enable` for 4 cycles mid-phase → phase resumes where it stopped. A load mid-phase restarts the 3-cycle spacing.
- SAT down: load 2, `up_dn`=0, `mode`=SAT → `q` 1, 0, 0, 0 with `tc` pulsing on each tick at 0. Load `load_value`=9 with `limit`=6 → `q`=6.
- ONESHOT: `limit`=3 from 0, up → `q` 1,2,3. On the terminal tick `tc`=1 once and `done`=1; `q` stays 3 for 10 more enabled cycles with no further `tc`. Load 0 → `done`=0 and counting resumes.
- BOUNCE: `limit`=3, load 0 with `up_dn`=1 → `q` 1,2,3,2,1,0,1,2. `tc` pulses at the steps leaving 3 and leaving 0. With `limit`=0 → `q`=0 constantly, `tc` on every tick.
- Edge cases: lower `limit` from 200 to 10 while `cnt`=50 in WRAP up → next tick gives `q`=0 with `tc`. `oe`=0 → `q`=0 while the internal count continues, and the correct value reappears on `oe`=1.
